ibex_bloom_unit: RTL and testbench
==================================

# ibex_bloom_unit

Parametrised multi-cycle Bloom-filter accelerator for the Ibex EX stage, driven by the custom-instruction path alongside the ALU and multiplier/divider. It supports a configurable filter size and hash count, and handles insert, membership check, clear and insert-count operations. Operands come from RS1 (key) and RS2 (seed). Completion is signalled with a ready/valid handshake so the EX stage can stall exactly as it does for multdiv.

## Interface

Clock is `clk_i`, reset is `rst_i`; single clock; reset is synchronous and active-high.

**Parameters**
- `FilterBits`, default 1024: filter size in bits. Must be a power of two, 64..65536.
- `NumHashes`, default 3: hash functions per key, 1..8.

**Ports**
- `clk_i` input, 1: clock.
- `rst_i` input, 1: synchronous active-high reset.
- `en_i` input, 1: operation request.
- `op_i` input, 5: operation code.
- `operand_a_i` input, 32: key (RS1).
- `operand_b_i` input, 32: seed (RS2).
- `flush_i` input, 1: abort the in-flight operation (pipeline kill).
- `ready_o` output, 1: unit can accept a request this cycle.
- `valid_o` output, 1: single-cycle completion pulse.
- `result_o` output, 32: result, held until the next completion.
- `illegal_o` output, 1: unsupported op; qualified by `valid_o`.

## Operation

**Accept:** a request is accepted when `en_i && ready_o && !flush_i`. `op_i`, `operand_a_i` and `operand_b_i` are latched. `en_i` is ignored while `ready_o` is low.

**Op codes**
- INSERT = 1
- CHECK = 2
- CLEAR = 3
- COUNT = 4
- Any other value is illegal.

**Hash k** (k = 0..NumHashes-1)
- x = rotl(key, 5k) ^ (seed + k*32'h9E3779B9), all modulo 2^32.
- f = x[31:16] ^ x[15:0].
- idx = f[IdxW-1:0], where IdxW = $clog2(FilterBits).

**FSM:** IDLE → HASH / CLEAR / DONE; HASH → DONE; CLEAR → DONE; DONE → IDLE, or straight into a new op if accepted in DONE.

**Per-op behaviour**
- INSERT: one HASH cycle per k. Each cycle reads bit[idx] and sets it in the same cycle. result_o = 1 if every read bit was already 1 (key probably present), else 0. Reads see writes from earlier k of the same op, so duplicate indices read as set. The 16-bit insert counter increments (saturating at 0xFFFF) at DONE.
- CHECK: reads bit[idx] per k. result_o = 1 if all bits are set, else 0. Never writes.
- CLEAR: a word counter zeroes 32 bits per cycle for FilterBits/32 cycles. The insert counter is zeroed at DONE. result_o = 0.
- COUNT: result_o = {16'b0, insert_count}.
- Illegal op: result_o = 0, illegal_o = 1, filter untouched.

**Flush:** flush_i in any non-IDLE state returns the FSM to IDLE next cycle with no valid_o.
- Bits already set by a partial INSERT remain set.
- A partial CLEAR leaves the filter partially cleared and the insert counter unchanged.
- flush_i together with en_i blocks acceptance.

**Reset values:**
- State IDLE.
- ready_o = 1, valid_o = 0, result_o = 0, illegal_o = 0.
- Filter all-zero, insert counter 0, word counter 0, hash counter 0.
- Reset mid-operation abandons the op with no valid_o.

## Timing

- Accept at cycle t. ready_o is low from t+1 until DONE and high in DONE, so back-to-back issue is possible.
- INSERT: HASH cycles t+1..t+NumHashes; valid_o at t+NumHashes+1.
- CHECK: same as INSERT, except early exit when configured (see Configuration).
- CLEAR: valid_o at t+FilterBits/32+1.
- COUNT and illegal ops: valid_o at t+1.
- valid_o is high for exactly one cycle. result_o and illegal_o update in the same cycle and hold afterwards.
- CHECK issued in the DONE cycle of an INSERT observes all of that INSERT's writes.

## Configuration

- `IBEX_BLOOM_EARLY_EXIT_EN` defined: CHECK moves to DONE in the cycle after the first zero bit is read. A miss at hash j gives valid_o at t+j+2.
- Undefined: CHECK always runs NumHashes cycles (data-independent timing, matching data_ind_timing requirements). Results are identical in both builds.

## Structure

- `ibex_bloom_pkg` holds:
  - `bloom_op_e` (5-bit op enum);
  - `bloom_state_e` (IDLE, HASH, CLEAR, DONE);
  - constant `BloomHashGolden` = 32'h9E3779B9;
  - `BloomCountW` = 16.
- Sub-module `ibex_bloom_hash`, parametrised by IdxW: combinational key/seed/k → idx.
- The filter is a flop array, addressed per bit for HASH and per 32-bit word for CLEAR.

## Test plan

All scenarios use FilterBits=1024, NumHashes=3.

- **Reset:** assert rst_i, then release → ready_o=1, valid_o=0, result_o=0. CHECK of key 0x12345678, seed 0 → result 0.
- **Insert then check:** INSERT key 0x12345678, seed 0 → valid_o at t+4, result 0, COUNT = 1. Re-INSERT the same key → result 1, COUNT = 2. CHECK it → result 1.
- **CLEAR:** after the inserts above, CLEAR → valid_o at t+33. CHECK 0x12345678 → 0 (at t+2 with early exit, t+4 without). COUNT → 0.
- **Flush:** INSERT with flush_i at t+2 → no valid_o, ready_o=1 at t+3, COUNT unchanged.
- **Illegal op and back-to-back:** op 7 → valid_o at t+1, illegal_o=1, result 0. Then issue INSERT during DONE → accepted, valid_o 4 cycles later.
- **Counter saturation:** force insert_count to 0xFFFF, INSERT → COUNT returns 0x0000FFFF.

Source files
------------

// File: rtl/ibex_bloom_pkg.sv
// Shared types and constants for the Ibex Bloom-filter accelerator.
package ibex_bloom_pkg;

  typedef enum logic [4:0] {
    BloomOpInsert = 5'd1,
    BloomOpCheck  = 5'd2,
    BloomOpClear  = 5'd3,
    BloomOpCount  = 5'd4
  } bloom_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StHash,
    StClear,
    StDone
  } bloom_state_e;

  localparam logic [31:0] BloomHashGolden = 32'h9E3779B9;
  localparam int unsigned BloomCountW     = 16;

endpackage

// File: rtl/ibex_bloom_hash.sv
// Combinational Bloom hash: rotate key by 5k, mix with golden-ratio-stepped seed, fold to 16 bits.
module ibex_bloom_hash
  import ibex_bloom_pkg::*;
#(
  parameter int unsigned IdxW = 10
) (
  input  logic [31:0]     key_i,
  input  logic [31:0]     seed_i,
  input  logic [2:0]      k_i,
  output logic [IdxW-1:0] idx_o
);

  logic [4:0]  rot_amt;
  logic [31:0] key_rot;
  logic [31:0] seed_mix;
  logic [31:0] x;
  logic [15:0] f;

  // 5k wraps modulo 32, which is exactly a rotate by 5k.
  assign rot_amt  = {2'b00, k_i} * 5'd5;
  // A shift by 32 yields zero, so rot_amt == 0 degrades cleanly to key_i.
  assign key_rot  = (key_i << rot_amt) | (key_i >> (6'd32 - {1'b0, rot_amt}));
  assign seed_mix = seed_i + ({29'b0, k_i} * BloomHashGolden);
  assign x        = key_rot ^ seed_mix;
  assign f        = x[31:16] ^ x[15:0];
  assign idx_o    = f[IdxW-1:0];

  if (IdxW < 16) begin : g_fold_unused
    logic unused_f_hi;
    assign unused_f_hi = ^f[15:IdxW];
  end

endmodule

// File: rtl/ibex_bloom_unit.sv
// Multi-cycle Bloom-filter unit for the Ibex EX stage (insert/check/clear/count).
// Define IBEX_BLOOM_EARLY_EXIT_EN to let CHECK finish on the first zero bit.
module ibex_bloom_unit
  import ibex_bloom_pkg::*;
#(
  parameter int unsigned FilterBits = 1024,
  parameter int unsigned NumHashes  = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [4:0]  op_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic        illegal_o
);

  localparam int unsigned IdxW     = $clog2(FilterBits);
  localparam int unsigned NumWords = FilterBits / 32;
  localparam int unsigned WordW    = $clog2(NumWords);
  localparam logic [2:0]       LastK    = 3'(NumHashes - 1);
  localparam logic [WordW-1:0] LastWord = WordW'(NumWords - 1);

  bloom_state_e            state_q, state_d;
  logic [4:0]              op_q, op_d;
  logic [31:0]             key_q, key_d;
  logic [31:0]             seed_q, seed_d;
  logic [2:0]              k_q, k_d;
  logic [WordW-1:0]        word_q, word_d;
  logic                    hit_q, hit_d;
  logic [BloomCountW-1:0]  count_q, count_d;
  logic [31:0]             result_q, result_d;
  logic                    illegal_q, illegal_d;
  logic [FilterBits-1:0]   filter_q, filter_d;

  logic [IdxW-1:0] idx;
  logic            bit_rd;
  logic            ready;
  logic            accept;
  logic            early_exit;

  ibex_bloom_hash #(
    .IdxW(IdxW)
  ) u_hash (
    .key_i (key_q),
    .seed_i(seed_q),
    .k_i   (k_q),
    .idx_o (idx)
  );

  assign ready  = (state_q == StIdle) || (state_q == StDone);
  assign accept = en_i & ready & ~flush_i;
  assign bit_rd = filter_q[idx];

`ifdef IBEX_BLOOM_EARLY_EXIT_EN
  assign early_exit = (op_q == BloomOpCheck) & ~bit_rd;
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    key_d     = key_q;
    seed_d    = seed_q;
    k_d       = k_q;
    word_d    = word_q;
    hit_d     = hit_q;
    count_d   = count_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    filter_d  = filter_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          op_d   = op_i;
          key_d  = operand_a_i;
          seed_d = operand_b_i;
          k_d    = '0;
          word_d = '0;
          hit_d  = 1'b1;
          case (op_i)
            BloomOpInsert, BloomOpCheck: state_d = StHash;
            BloomOpClear:                state_d = StClear;
            BloomOpCount: begin
              result_d  = 32'(count_q);
              illegal_d = 1'b0;
              state_d   = StDone;
            end
            default: begin
              result_d  = '0;
              illegal_d = 1'b1;
              state_d   = StDone;
            end
          endcase
        end
      end

      StHash: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          // Registered filter means earlier k of this op are already visible here.
          if (op_q == BloomOpInsert) begin
            filter_d[idx] = 1'b1;
          end
          hit_d = hit_q & bit_rd;
          if ((k_q == LastK) || early_exit) begin
            result_d  = {31'b0, hit_q & bit_rd};
            illegal_d = 1'b0;
            state_d   = StDone;
            if ((op_q == BloomOpInsert) && (count_q != '1)) begin
              count_d = count_q + 1'b1;
            end
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end

      StClear: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          filter_d[{word_q, 5'b0} +: 32] = '0;
          if (word_q == LastWord) begin
            count_d   = '0;
            result_d  = '0;
            illegal_d = 1'b0;
            state_d   = StDone;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      op_q      <= '0;
      key_q     <= '0;
      seed_q    <= '0;
      k_q       <= '0;
      word_q    <= '0;
      hit_q     <= 1'b0;
      count_q   <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      filter_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      key_q     <= key_d;
      seed_q    <= seed_d;
      k_q       <= k_d;
      word_q    <= word_d;
      hit_q     <= hit_d;
      count_q   <= count_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      filter_q  <= filter_d;
    end
  end

  assign ready_o   = ready;
  assign valid_o   = (state_q == StDone);
  assign result_o  = result_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_ibex_bloom_unit.sv
// Randomised bench for ibex_bloom_unit against a set-of-bits reference model.
module tb_ibex_bloom_unit;

  localparam int FB = 1024;
  localparam int NH = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [4:0]  op_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        flush_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  bit model_bits[FB];
  int model_count;

  always #5 clk_i = ~clk_i;

  ibex_bloom_unit #(
    .FilterBits(FB),
    .NumHashes (NH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .op_i       (op_i),
    .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i),
    .flush_i    (flush_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .illegal_o  (illegal_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int ref_idx(input logic [31:0] key, input logic [31:0] seed, input int k);
    int          s;
    logic [31:0] rot;
    logic [31:0] x;
    logic [15:0] f;
    s   = (5 * k) % 32;
    rot = (s == 0) ? key : ((key << s) | (key >> (32 - s)));
    x   = rot ^ (seed + 32'(k) * 32'h9E3779B9);
    f   = x[31:16] ^ x[15:0];
    return int'(f) % FB;
  endfunction

  task automatic model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ill, output int lat);
    bit all_set;
    int miss;
    int i;
    res  = 0;
    ill  = 1'b0;
    miss = -1;
    case (op)
      5'd1: begin
        all_set = 1'b1;
        for (int k = 0; k < NH; k++) begin
          i = ref_idx(a, b, k);
          if (!model_bits[i]) all_set = 1'b0;
          model_bits[i] = 1'b1;
        end
        res = 32'(all_set);
        lat = NH + 1;
        if (model_count < 65535) model_count++;
      end
      5'd2: begin
        all_set = 1'b1;
        for (int k = 0; k < NH; k++) begin
          i = ref_idx(a, b, k);
          if (!model_bits[i] && all_set) begin
            miss    = k;
            all_set = 1'b0;
          end
        end
        res = 32'(all_set);
        lat = NH + 1;
`ifdef IBEX_BLOOM_EARLY_EXIT_EN
        if (miss >= 0) lat = miss + 2;
`endif
      end
      5'd3: begin
        foreach (model_bits[j]) model_bits[j] = 1'b0;
        model_count = 0;
        lat = FB / 32 + 1;
      end
      5'd4: begin
        res = 32'(model_count);
        lat = 1;
      end
      default: begin
        ill = 1'b1;
        lat = 1;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic dut_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic ill);
    check_eq("ready_at_issue", 32'(ready_o), 32'd1);
    en_i        = 1'b1;
    op_i        = op;
    operand_a_i = a;
    operand_b_i = b;
    step();
    lat = 1;
    en_i = 1'b0;
    while (!valid_o && lat < 200) begin
      check_eq("busy_ready_low", 32'(ready_o), 32'd0);
      // Requests while busy must be ignored.
      en_i        = 1'($urandom);
      op_i        = 5'($urandom);
      operand_a_i = $urandom;
      operand_b_i = $urandom;
      step();
      lat++;
    end
    en_i = 1'b0;
    res  = result_o;
    ill  = illegal_o;
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] eres, res;
    logic        eill, ill;
    int          elat, lat;
    model_op(op, a, b, eres, eill, elat);
    dut_op(op, a, b, lat, res, ill);
    check_eq({tag, "_result"}, res, eres);
    check_eq({tag, "_illegal"}, 32'(ill), 32'(eill));
    check_eq({tag, "_latency"}, 32'(lat), 32'(elat));
  endtask

  logic [31:0] keys[6];
  logic [31:0] seeds[2];

  initial begin
    logic [31:0] held;
    int          r;
    logic [4:0]  op;
    logic [31:0] key;

    rst_i       = 1'b1;
    en_i        = 1'b0;
    flush_i     = 1'b0;
    op_i        = '0;
    operand_a_i = '0;
    operand_b_i = '0;
    model_count = 0;
    repeat (3) step();
    rst_i = 1'b0;
    step();

    check_eq("reset_ready", 32'(ready_o), 32'd1);
    check_eq("reset_valid", 32'(valid_o), 32'd0);
    check_eq("reset_result", result_o, 32'd0);
    check_eq("reset_illegal", 32'(illegal_o), 32'd0);

    run_op("chk_empty", 5'd2, 32'h12345678, 32'h0);
    run_op("ins_first", 5'd1, 32'h12345678, 32'h0);
    run_op("cnt_one", 5'd4, 32'h0, 32'h0);
    run_op("ins_again", 5'd1, 32'h12345678, 32'h0);
    run_op("cnt_two", 5'd4, 32'h0, 32'h0);
    run_op("chk_hit", 5'd2, 32'h12345678, 32'h0);
    run_op("clear", 5'd3, 32'h0, 32'h0);
    run_op("chk_after_clr", 5'd2, 32'h12345678, 32'h0);
    run_op("cnt_after_clr", 5'd4, 32'h0, 32'h0);
    run_op("ins_pre_flush", 5'd1, 32'hCAFEF00D, 32'h5);

    // Flush during the second HASH cycle of an INSERT.
    step();
    en_i        = 1'b1;
    op_i        = 5'd1;
    operand_a_i = 32'hDEADBEEF;
    operand_b_i = 32'h1;
    step();
    en_i = 1'b0;
    check_eq("flush_busy_ready", 32'(ready_o), 32'd0);
    step();
    flush_i = 1'b1;
    check_eq("flush_t2_valid", 32'(valid_o), 32'd0);
    step();
    flush_i = 1'b0;
    check_eq("flush_t3_ready", 32'(ready_o), 32'd1);
    check_eq("flush_t3_valid", 32'(valid_o), 32'd0);
    step();
    check_eq("flush_t4_valid", 32'(valid_o), 32'd0);
    run_op("cnt_after_flush", 5'd4, 32'h0, 32'h0);
    run_op("clr_after_flush", 5'd3, 32'h0, 32'h0);

    // Flush alongside a request blocks acceptance.
    step();
    en_i    = 1'b1;
    op_i    = 5'd4;
    flush_i = 1'b1;
    step();
    en_i    = 1'b0;
    flush_i = 1'b0;
    check_eq("flush_blocks_valid", 32'(valid_o), 32'd0);
    check_eq("flush_blocks_ready", 32'(ready_o), 32'd1);

    // Illegal op followed by back-to-back INSERT issued in its DONE cycle.
    run_op("illegal7", 5'd7, 32'h0, 32'h0);
    run_op("b2b_insert", 5'd1, 32'h12345678, 32'h0);
    run_op("b2b_check", 5'd2, 32'h12345678, 32'h0);

    foreach (keys[i]) keys[i] = $urandom;
    seeds[0] = 32'h0;
    seeds[1] = $urandom;
    held = result_o;
    for (int n = 0; n < 300; n++) begin
      r   = $urandom_range(0, 99);
      key = ($urandom_range(0, 9) == 0) ? $urandom : keys[$urandom_range(0, 5)];
      if (r < 35)      op = 5'd1;
      else if (r < 70) op = 5'd2;
      else if (r < 82) op = 5'd4;
      else if (r < 92) op = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(5, 31));
      else             op = 5'd3;
      run_op("rand", op, key, seeds[$urandom_range(0, 1)]);
      held = result_o;
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        step();
        check_eq("gap_valid_low", 32'(valid_o), 32'd0);
        check_eq("gap_result_hold", result_o, held);
      end
    end

    // Reset in the middle of an INSERT abandons it.
    en_i        = 1'b1;
    op_i        = 5'd1;
    operand_a_i = 32'h0BADF00D;
    operand_b_i = 32'h0;
    step();
    en_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    foreach (model_bits[j]) model_bits[j] = 1'b0;
    model_count = 0;
    check_eq("midrst_valid", 32'(valid_o), 32'd0);
    check_eq("midrst_ready", 32'(ready_o), 32'd1);
    check_eq("midrst_result", result_o, 32'd0);
    step();
    check_eq("midrst_valid_late", 32'(valid_o), 32'd0);
    run_op("cnt_after_rst", 5'd4, 32'h0, 32'h0);

    // Insert counter saturation.
    step();
    force dut.count_q = 16'hFFFF;
    step();
    release dut.count_q;
    model_count = 65535;
    run_op("sat_insert", 5'd1, 32'h12345678, 32'h0);
    run_op("sat_count", 5'd4, 32'h0, 32'h0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
